// File: rtl/din_serializer_if.sv
// din_serializer_if
// Word handshake and serial output bundle for din_serializer.
//   data_in   : word to serialize (master -> slave)
//   valid_in  : data_in valid (master -> slave)
//   ready_out : serializer can accept a word (slave -> master)
//   sout      : serial bit stream, MSB first (slave -> master)
//   busy      : serializer is shifting or inserting the gap (slave -> master)
//   done      : one-cycle pulse on the last bit of a word (slave -> master)
interface din_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  sout,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output sout,
    output busy,
    output done
  );
endinterface

// File: rtl/din_serializer.sv
// din_serializer
// Parallel-to-serial stage feeding the pulse-pairing FSM's din input.
// Words arrive over valid/ready into a one-word holding register, are shifted
// out MSB-first one bit per clock, and each word is followed by GAP zero cycles.
//
// Ports:
//   clk  : single clock, all state updates on posedge
//   rst  : asynchronous active-high reset
//   bus  : din_serializer_if slave modport (data_in, valid_in, ready_out,
//          sout, busy, done)
//
// Parameters:
//   WIDTH : data bits per word (>= 2)
//   GAP   : zero cycles inserted after each word (>= 0)
//
// Optional feature macro: SER_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) follows the LSB
//   and done pulses on that parity bit instead of the LSB.
module din_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic            clk,
  input  logic            rst,
  din_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = $clog2(NBITS + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [GW-1:0]    gapcnt, gapcnt_n;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             sout_r, sout_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             drain_s;
  logic             accept_s;
  logic             ready_s;
  logic             fill_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign ready_s       = ~hold_full & ~rst;
  assign accept_s      = bus.valid_in & ready_s;
  assign bus.ready_out = ready_s;
  assign bus.sout      = sout_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // The first data bit leaves on the load edge itself, so the shifter keeps
  // only the remaining bits; with parity, the parity bit is parked in the
  // vacated LSB and falls out naturally after the data LSB.
`ifdef SER_PARITY_EN
  assign fill_s = even_parity(hold_data);
`else
  assign fill_s = 1'b0;
`endif

  // Next-state and next-output decode for the IDLE/SHIFT/GAP sequencer.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    gapcnt_n = gapcnt;
    sout_n   = 1'b0;
    done_n   = 1'b0;
    drain_s  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          drain_s  = 1'b1;
          state_n  = ST_SHIFT;
          sout_n   = hold_data[WIDTH-1];
          shreg_n  = {hold_data[WIDTH-2:0], fill_s};
          bitcnt_n = BW'(1);
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bitcnt == BW'(NBITS)) begin
          // Last bit has just been on sout for a cycle.
          if (GAP > 0) begin
            state_n  = ST_GAP;
            gapcnt_n = GW'(1);
          end else if (hold_full) begin
            drain_s  = 1'b1;
            state_n  = ST_SHIFT;
            sout_n   = hold_data[WIDTH-1];
            shreg_n  = {hold_data[WIDTH-2:0], fill_s};
            bitcnt_n = BW'(1);
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          sout_n   = shreg[WIDTH-1];
          shreg_n  = {shreg[WIDTH-2:0], 1'b0};
          bitcnt_n = bitcnt + BW'(1);
          done_n   = ((bitcnt + BW'(1)) == BW'(NBITS));
        end
      end
      ST_GAP: begin
        if (gapcnt == GW'(GAP)) begin
          if (hold_full) begin
            drain_s  = 1'b1;
            state_n  = ST_SHIFT;
            sout_n   = hold_data[WIDTH-1];
            shreg_n  = {hold_data[WIDTH-2:0], fill_s};
            bitcnt_n = BW'(1);
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          gapcnt_n = gapcnt + GW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Sequencer state, shifter, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= {WIDTH{1'b0}};
      bitcnt <= {BW{1'b0}};
      gapcnt <= {GW{1'b0}};
      sout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      gapcnt <= gapcnt_n;
      sout_r <= sout_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  // Holding register: drain and accept are mutually exclusive because
  // ready is low whenever the register is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= {WIDTH{1'b0}};
    end else if (drain_s) begin
      hold_full <= 1'b0;
    end else if (accept_s) begin
      hold_full <= 1'b1;
      hold_data <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_din_serializer.sv
// tb_din_serializer
// Two serializers (GAP=2 and GAP=0) driven from per-instance word queues and
// compared every cycle against a timing model: each word starts at
// max(accept+1, previous start + bits + GAP), and from that start its bits,
// done pulse and busy window follow by simple arithmetic.
module tb_din_serializer;
  localparam int W     = 8;
  localparam int NI    = 2;
  localparam int DEPTH = 8192;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  int gapv [NI] = '{2, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  din_serializer_if #(.WIDTH(W)) if0 ();
  din_serializer_if #(.WIDTH(W)) if1 ();

  din_serializer #(.WIDTH(W), .GAP(2)) u0 (.clk(clk), .rst(rst), .bus(if0));
  din_serializer #(.WIDTH(W), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(if1));

  logic [W-1:0] din [NI] = '{8'h00, 8'h00};
  logic         vin [NI] = '{1'b0, 1'b0};
  logic so_s [NI];
  logic bz_s [NI];
  logic dn_s [NI];
  logic rd_s [NI];

  assign if0.data_in  = din[0];
  assign if0.valid_in = vin[0];
  assign if1.data_in  = din[1];
  assign if1.valid_in = vin[1];
  assign so_s[0] = if0.sout;
  assign so_s[1] = if1.sout;
  assign bz_s[0] = if0.busy;
  assign bz_s[1] = if1.busy;
  assign dn_s[0] = if0.done;
  assign dn_s[1] = if1.done;
  assign rd_s[0] = if0.ready_out;
  assign rd_s[1] = if1.ready_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state
  bit           exp_so [NI][DEPTH];
  bit           exp_dn [NI][DEPTH];
  bit           exp_bz [NI][DEPTH];
  bit           dut_so [NI][DEPTH];
  bit           dut_dn [NI][DEPTH];
  bit           dut_bz [NI][DEPTH];
  bit           m_hold [NI];
  logic [W-1:0] m_hdata [NI];
  int           m_ha [NI];
  int           m_free [NI];
  bit           acc_flag [NI];
  int           starts [NI][256];
  int           ns [NI];

  // stimulus state
  logic [W-1:0] txq0 [$];
  logic [W-1:0] txq1 [$];
  int           idle_cnt [NI];
  bit           rnd_mode = 1'b0;

  task automatic chk(input string nm, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%b exp=%b", nm, i, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic bit q_empty(input int i);
    if (i == 0) return (txq0.size() == 0);
    else return (txq1.size() == 0);
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) begin
      if (!q_empty(i) || vin[i] || m_hold[i] || (cyc < m_free[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_start(input int i, input int t, input logic [W-1:0] w);
    for (int b = 0; b < NB; b++) begin
      if (t + b < DEPTH) exp_so[i][t+b] = (b < W) ? w[W-1-b] : ^w;
    end
    if (t + NB - 1 < DEPTH) exp_dn[i][t+NB-1] = 1'b1;
    for (int b = 0; b < NB + gapv[i]; b++) begin
      if (t + b < DEPTH) exp_bz[i][t+b] = 1'b1;
    end
    m_free[i] = t + NB + gapv[i];
    if (ns[i] < 256) starts[i][ns[i]] = t;
    ns[i]++;
  endtask

  // reference model: advances on every active edge
  always @(posedge clk) begin
    bit acc;
    int ts;
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_hold[i]   = 1'b0;
        m_free[i]   = 0;
        acc_flag[i] = 1'b0;
        for (int c = cyc; c < DEPTH; c++) begin
          exp_so[i][c] = 1'b0;
          exp_dn[i][c] = 1'b0;
          exp_bz[i][c] = 1'b0;
        end
      end else begin
        acc = vin[i] && !m_hold[i];
        if (m_hold[i]) begin
          ts = (m_ha[i] + 1 > m_free[i]) ? m_ha[i] + 1 : m_free[i];
          if (cyc >= ts) begin
            m_start(i, cyc, m_hdata[i]);
            m_hold[i] = 1'b0;
          end
        end
        if (acc) begin
          m_hold[i]  = 1'b1;
          m_hdata[i] = din[i];
          m_ha[i]    = cyc;
        end
        acc_flag[i] = acc;
      end
    end
  end

  // compare on the inactive edge, then drive the next inputs
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (cyc < DEPTH) begin
        dut_so[i][cyc] = so_s[i];
        dut_dn[i][cyc] = dn_s[i];
        dut_bz[i][cyc] = bz_s[i];
        if (rst) begin
          chk("sout_rst", i, so_s[i], 1'b0);
          chk("busy_rst", i, bz_s[i], 1'b0);
          chk("done_rst", i, dn_s[i], 1'b0);
          chk("ready_rst", i, rd_s[i], 1'b0);
        end else begin
          chk("sout", i, so_s[i], exp_so[i][cyc]);
          chk("busy", i, bz_s[i], exp_bz[i][cyc]);
          chk("done", i, dn_s[i], exp_dn[i][cyc]);
          chk("ready", i, rd_s[i], !m_hold[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        vin[i] = 1'b0;
      end else begin
        if (acc_flag[i]) begin
          vin[i]      = 1'b0;
          acc_flag[i] = 1'b0;
        end
        if (!vin[i] && !q_empty(i)) begin
          if (idle_cnt[i] > 0) begin
            idle_cnt[i]--;
          end else begin
            if (i == 0) din[i] = txq0.pop_front();
            else din[i] = txq1.pop_front();
            vin[i]      = 1'b1;
            idle_cnt[i] = rnd_mode ? int'($urandom_range(0, 3)) : 0;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!all_idle() && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!all_idle()) begin
      failures++;
      $display("FAIL wait_idle timeout after %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_pat(input string nm, input int i, input int s, input int len,
                         input logic [31:0] sp, input logic [31:0] dp);
    logic [31:0] gs, gd, ms;
    gs = 32'd0;
    gd = 32'd0;
    ms = 32'd0;
    for (int b = 0; b < len; b++) begin
      if (s + b < DEPTH) begin
        gs[len-1-b] = dut_so[i][s+b];
        gd[len-1-b] = dut_dn[i][s+b];
        ms[len-1-b] = exp_so[i][s+b];
      end
    end
    chk_vec({nm, "_sout"}, gs, sp);
    chk_vec({nm, "_done"}, gd, dp);
    chk_vec({nm, "_model"}, ms, sp);
  endtask

  initial begin
    int n0, n1, s, k;
    logic [7:0] w;

    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n0, n1, s, k;
    logic [7:0] w;

    // reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_sout", 0, if0.sout, 1'b0);
    chk("rst_busy", 0, if0.busy, 1'b0);
    chk("rst_ready", 0, if0.ready_out, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 0, if0.ready_out, 1'b1);
    chk("ready_after_rst", 1, if1.ready_out, 1'b1);
    @(negedge clk);

    // single word A5 on GAP=2
    n0 = ns[0];
    txq0.push_back(8'hA5);
    wait_idle(100);
    s = starts[0][n0];
`ifdef SER_PARITY_EN
    chk_pat("a5", 0, s, 11, 32'(11'b10100101000), 32'(11'b00000000100));
`else
    chk_pat("a5", 0, s, 10, 32'(10'b1010010100), 32'(10'b0000000100));
`endif
    chk("a5_busy_gap", 0, dut_bz[0][s+NB+1], 1'b1);
    chk("a5_busy_fall", 0, dut_bz[0][s+NB+2], 1'b0);

    // back-to-back FF, 01 on GAP=2
    n0 = ns[0];
    txq0.push_back(8'hFF);
    txq0.push_back(8'h01);
    wait_idle(200);
    s = starts[0][n0];
    chk_vec("b2b_period", 32'(starts[0][n0+1] - s), 32'(NB + 2));
`ifdef SER_PARITY_EN
    chk_pat("b2b", 0, s, 20, 32'(20'b11111111000000000011), 32'(20'b00000000100000000001));
`else
    chk_pat("b2b", 0, s, 18, 32'(18'b111111110000000001), 32'(18'b000000010000000001));
`endif

    // GAP=0 stream 81, 81
    n1 = ns[1];
    txq1.push_back(8'h81);
    txq1.push_back(8'h81);
    wait_idle(200);
    s = starts[1][n1];
`ifdef SER_PARITY_EN
    chk_pat("gap0", 1, s, 18, 32'(18'b100000010100000010), 32'(18'b000000001000000001));
`else
    chk_pat("gap0", 1, s, 16, 32'(16'b1000000110000001), 32'(16'b0000000100000001));
`endif

    // A5 then 07 on GAP=2 (parity bits 0 and 1 when enabled)
    n0 = ns[0];
    txq0.push_back(8'hA5);
    txq0.push_back(8'h07);
    wait_idle(200);
    s = starts[0][n0];
    chk_vec("a5_07_period", 32'(starts[0][n0+1] - s), 32'(NB + 2));
`ifdef SER_PARITY_EN
    chk_pat("a5_07", 0, s, 22, 32'(22'b1010010100000000111100), 32'(22'b0000000010000000000100));
`else
    chk_pat("a5_07", 0, s, 20, 32'(20'b10100101000000011100), 32'(20'b00000001000000000100));
`endif

    // asynchronous reset during the 4th bit of F0
    n0 = ns[0];
    txq0.push_back(8'hF0);
    k = 0;
    while (ns[0] == n0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ns[0] == n0) begin
      failures++;
      $display("FAIL f0_start timeout");
    end
    s = starts[0][n0];
    while (cyc < s + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("f0_bit4_before_rst", 0, if0.sout, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sout", 0, if0.sout, 1'b0);
    chk("arst_busy", 0, if0.busy, 1'b0);
    chk("arst_done", 0, if0.done, 1'b0);
    chk("arst_ready", 0, if0.ready_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ready_after_arst", 0, if0.ready_out, 1'b1);
    repeat (4) @(negedge clk);
    n0 = ns[0];
    txq0.push_back(8'h3C);
    wait_idle(100);
    s = starts[0][n0];
`ifdef SER_PARITY_EN
    chk_pat("post_rst", 0, s, 11, 32'(11'b00111100000), 32'(11'b00000000100));
`else
    chk_pat("post_rst", 0, s, 10, 32'(10'b0011110000), 32'(10'b0000000100));
`endif

    // randomized traffic on both instances
    rnd_mode = 1'b1;
    for (int j = 0; j < 80; j++) begin
      w = 8'($urandom);
      txq0.push_back(w);
      w = 8'($urandom);
      txq1.push_back(w);
    end
    wait_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/din_serializer.md
# din_serializer

Parallel-to-serial stage that sits directly upstream of the pulse-pairing FSM and drives that block's `din` input. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out MSB-first, one bit per clock. A programmable run of zero cycles follows each word before the next one starts.

## Interface
- `WIDTH`, 8: data bits per word, ≥2.
- `GAP`, 2: zero cycles inserted on `sout` after each word, ≥0.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_in`  in  WIDTH  word to serialize.
- `valid_in`  in  1  `data_in` valid.
- `ready_out`  out  1  holding register can accept; equals `~hold_full & ~rst`.
- `sout`  out  1  serial bit stream, registered; connects to the downstream `din`.
- `busy`  out  1  registered; high when state ≠ IDLE.
- `done`  out  1  registered one-cycle pulse, high while the last bit of a word is on `sout`.

## Operation
- Internal registers: `state`, `shreg[WIDTH-1:0]`, bit counter, gap counter, `hold_data`, `hold_full`.
- Accept: `valid_in & ready_out` at a posedge. On accept, the edge writes `hold_data` and sets `hold_full`.
- While `hold_full=1`, `ready_out=0`. Accept and drain never occur on the same edge, so a new word is refused in the cycle the hold register drains.
- State machine, states IDLE, SHIFT, GAP:
  - **IDLE**: `sout=0`. If `hold_full`, load `shreg←hold_data`, clear `hold_full`, and go to SHIFT.
  - **SHIFT**: `sout=shreg[MSB]`, then shift left. Count WIDTH bits, or WIDTH+1 with parity.
    - After the last bit, go to GAP if `GAP>0`.
    - If `GAP=0` and `hold_full`, reload directly and stay in SHIFT.
    - Otherwise go to IDLE.
  - **GAP**: `sout=0` for exactly GAP cycles. Then reload from hold and go to SHIFT if `hold_full`, else go to IDLE.
- A word accepted during SHIFT or GAP waits in hold. Back-to-back words are separated by exactly GAP zero cycles.
- `sout` is 0 in every cycle that is not a data or parity bit.
- Reset mid-operation: the in-flight word and the held word are discarded. The block restarts in IDLE. Nothing resumes.

## Timing
- Reset values: `sout=0`, `busy=0`, `done=0`, `ready_out=0` while `rst` is high, state IDLE, `hold_full=0`.
- First cycle after `rst` deasserts: `ready_out=1`.
- Latency: word accepted at edge N with the block in IDLE:
  - edge N+1 loads the shifter;
  - MSB is on `sout` during cycle N+1..N+2;
  - LSB is on `sout` WIDTH−1 cycles later;
  - `done` is high for that same cycle.
- Throughput: one word per WIDTH+GAP cycles (WIDTH+1+GAP with parity) when the hold register is kept full.
- `busy` rises with the first data bit. It falls in the first IDLE cycle after the trailing gap.

## Configuration
- Macro: `SER_PARITY_EN`.
- Defined: one even-parity bit (XOR of all WIDTH data bits) follows the LSB on `sout`. `done` pulses on the parity bit, and the bit counter runs to WIDTH+1.
- Undefined: no parity bit; `done` pulses on the LSB.

## Test plan
- **Single word, no parity.** Reset, then send `8'hA5` (GAP=2). Required:
  - `sout` = 1,0,1,0,0,1,0,1 on consecutive cycles starting 1 cycle after the accept edge;
  - `done` high only on the final 1;
  - 2 zero cycles follow; `busy` falls after the gap.
- **Back-to-back words.** Present `8'hFF` then `8'h01` with `valid_in` held high. Required:
  - second word accepted while the first is shifting;
  - `ready_out=0` until hold drains;
  - `sout` = eight 1s, two 0s, then 0000_0001.
- **GAP=0.** Stream `8'h81`, `8'h81`. Required: `sout` = 1000_0001_1000_0001 with no idle cycle between words.
- **Parity.** `SER_PARITY_EN` defined; send `8'hA5`, then `8'h07`. Required:
  - parity bits 0 and 1 respectively after each LSB;
  - `done` pulses on the parity bits;
  - word period 11 cycles.
- **Reset mid-word.** Assert `rst` asynchronously (between edges) during the 4th bit of `8'hF0`. Required:
  - `sout`, `busy`, `done` go 0 immediately and `ready_out=0` during reset;
  - after release, no remaining bits of `8'hF0` appear;
  - the next word serializes normally.
- **Downstream integration.** Drive the pulse-pairing FSM from `sout` and send `8'hA5`. Required: the downstream `dout` pulses exactly twice, once on the 2nd and once on the 4th `1` bit.
